// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle control sequencer.
// Steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared req/ack memory.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             regwrite,
  output logic [1:0]       aluop,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [7:0] MW = 8'(MAX_WAIT);

  state_t           r_state;
  logic [10:0]      r_op;
  logic [7:0]       r_wait;
  logic [1:0]       r_fault;
  logic [CNT_W-1:0] r_ret;

  logic w_r, w_ld, w_st, w_cbz, w_b, w_ill;
  logic w_tmo;

  always_comb begin
    w_r   = (r_op == 11'b10001011000) || (r_op == 11'b11001011000) ||
            (r_op == 11'b10001010000) || (r_op == 11'b10101010000);
    w_ld  = (r_op == 11'b11111000010);
    w_st  = (r_op == 11'b11111000000);
    w_cbz = (r_op[10:3] == 8'b10110100);
    w_b   = (r_op[10:5] == 6'b000101);
    w_ill = !(w_r || w_ld || w_st || w_cbz || w_b);
    w_tmo = (r_wait == MW);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_wait  <= '0;
      r_fault <= 2'b00;
      r_ret   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ack) begin
            r_op    <= opcode;
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_tmo) begin
            r_state <= S_HALT;
            r_fault <= 2'b10;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          if (w_ill) begin
            r_state <= S_HALT;
            r_fault <= 2'b01;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_r) begin
            r_state <= S_WB;
          end else if (w_ld || w_st) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_FETCH;
            r_ret   <= r_ret + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_wait <= '0;
            if (w_ld) begin
              r_state <= S_WB;
            end else begin
              r_state <= S_FETCH;
              r_ret   <= r_ret + CNT_W'(1);
            end
          end else if (w_tmo) begin
            r_state <= S_HALT;
            r_fault <= 2'b10;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_ret   <= r_ret + CNT_W'(1);
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_HALT;
          r_fault <= 2'b01;
        end
      endcase
    end
  end

  // Reset forces every control low asynchronously, even though state reads FETCH.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    reg2loc   = 1'b0;
    alusrc    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    aluop     = 2'b00;
    if (reset_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_inc   = mem_ack;
        end
        S_DECODE: reg2loc = w_st || w_cbz;
        S_EXEC: begin
          if (w_r) begin
            aluop = 2'b10;
          end else if (w_ld || w_st) begin
            alusrc  = 1'b1;
            reg2loc = w_st;
          end else if (w_cbz) begin
            aluop     = 2'b01;
            reg2loc   = 1'b1;
            pc_branch = zero;
          end else if (w_b) begin
            pc_branch = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = w_st;
          reg2loc = w_st;
          alusrc  = 1'b1;
        end
        S_WB: begin
          regwrite = 1'b1;
          memtoreg = w_ld;
          alusrc   = w_ld;
          aluop    = w_r ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign halted  = reset_n && (r_state == S_HALT);
  assign fault   = r_fault;
  assign retired = r_ret;

endmodule
